// File: rtl/accelbrot_com_ser_acc_deser.sv
// Word-serial add/subtract of block operand c against an LSW-first stream, reassembled into one block.
// Optional macro ACCELBROT_SER_ACC_SAT_EN saturates q on carry (add) or borrow (sub).
module accelbrot_com_ser_acc_deser #(
  parameter int NWORDS = 8,
  parameter int WWIDTH = 34,
  parameter int BWIDTH = NWORDS*WWIDTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WWIDTH-1:0] s_word,
  input  logic              s_start,
  input  logic              s_valid,
  input  logic [BWIDTH-1:0] c,
  input  logic              c_sub,
  output logic [BWIDTH-1:0] q,
  output logic              q_valid,
  output logic              q_carry,
  output logic              err
);

  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cy_q, cy_d;
  logic              sub_q, sub_d;
  logic [BWIDTH-1:0] c_q, c_d;
  logic [BWIDTH-1:0] q_q, q_d;
  logic              q_valid_q, q_valid_d;
  logic              q_carry_q, q_carry_d;
  logic              err_q, err_d;
  logic [WWIDTH-1:0] res_q [NWORDS];
  logic [WWIDTH-1:0] res_d [NWORDS];

  // A start word always uses the live c/c_sub and index 0, even mid-burst.
  logic [BWIDTH-1:0] c_sel;
  logic [CW-1:0]     idx;
  logic              sub_sel;
  logic              cin;
  logic [WWIDTH-1:0] op;
  logic [WWIDTH-1:0] c_words [NWORDS];
  logic [WWIDTH:0]   sum;
  logic              carry_flag;
  logic [BWIDTH-1:0] done_vec;
  logic [BWIDTH-1:0] q_done;

  assign c_sel      = s_start ? c : c_q;
  assign idx        = s_start ? '0 : cnt_q;
  assign sub_sel    = s_start ? c_sub : sub_q;
  assign cin        = s_start ? c_sub : cy_q;
  assign op         = sub_sel ? ~s_word : s_word;
  assign sum        = {1'b0, c_words[idx]} + {1'b0, op} + {{WWIDTH{1'b0}}, cin};
  assign carry_flag = sub_sel ? ~sum[WWIDTH] : sum[WWIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_word
      assign c_words[gi] = c_sel[gi*WWIDTH +: WWIDTH];
      // The top slot is taken straight from the adder so q lands one cycle after the last word.
      if (gi < NWORDS-1) begin : g_stored
        assign done_vec[gi*WWIDTH +: WWIDTH] = res_q[gi];
      end else begin : g_live
        assign done_vec[gi*WWIDTH +: WWIDTH] = sum[WWIDTH-1:0];
      end
    end
  endgenerate

`ifdef ACCELBROT_SER_ACC_SAT_EN
  assign q_done = carry_flag ? (sub_sel ? {BWIDTH{1'b0}} : {BWIDTH{1'b1}}) : done_vec;
`else
  assign q_done = done_vec;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cy_d      = cy_q;
    sub_d     = sub_q;
    c_d       = c_q;
    q_d       = q_q;
    q_carry_d = q_carry_q;
    q_valid_d = 1'b0;
    err_d     = 1'b0;
    res_d     = res_q;
    if (s_valid) begin
      if (state_q == IDLE && !s_start) begin
        err_d = 1'b1;
      end else begin
        if (s_start) begin
          err_d = (state_q == COLLECT);
          c_d   = c;
          sub_d = c_sub;
        end
        res_d[idx] = sum[WWIDTH-1:0];
        cy_d       = sum[WWIDTH];
        if (idx == CW'(NWORDS-1)) begin
          q_valid_d = 1'b1;
          q_d       = q_done;
          q_carry_d = carry_flag;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          state_d = COLLECT;
          cnt_d   = idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cy_q      <= 1'b0;
      sub_q     <= 1'b0;
      c_q       <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      q_carry_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cy_q      <= cy_d;
      sub_q     <= sub_d;
      c_q       <= c_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      q_carry_q <= q_carry_d;
      err_q     <= err_d;
    end
  end

  // Partial result slots carry no control meaning, so they are left out of reset.
  always_ff @(posedge clk) begin
    res_q <= res_d;
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign q_carry = q_carry_q;
  assign err     = err_q;

endmodule
